fp_addsub_seq: RTL and testbench



---
 rtl/fp_addsub_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle IEEE-754-style add/subtract with start/busy/done handshake.
// Define FP_ADDSUB_ROUND_EN to enable round-to-nearest-even; otherwise results are truncated.
module fp_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   op,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   result
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int M4 = MAN_W + 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_UNPACK = 3'd1;
    localparam logic [2:0] ST_ALIGN  = 3'd2;
    localparam logic [2:0] ST_ADD    = 3'd3;
    localparam logic [2:0] ST_NORM   = 3'd4;
`ifdef FP_ADDSUB_ROUND_EN
    localparam logic [2:0] ST_ROUND  = 3'd5;
`endif
    localparam logic [2:0] ST_DONE   = 3'd6;

    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    logic [2:0]       state_q, state_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
    logic             sx_q, sx_d, sy_q, sy_d;
    logic [EXP_W-1:0] ex_q, ex_d, diff_q, diff_d;
    logic [M4:0]      mx_q, mx_d;
    logic [M4-1:0]    my_q, my_d;

    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic             swap;

    logic [M4-1:0]    sh_val, sh_mask;
    logic             sh_lost;
    logic [M4:0]      sum;
    logic [EXP_W-1:0] ex_inc, ex_dec;

    assign sa = a_q[W-1];
    assign sb = b_q[W-1];
    assign ea = a_q[W-2:MAN_W];
    assign eb = b_q[W-2:MAN_W];
    assign fa = a_q[MAN_W-1:0];
    assign fb = b_q[MAN_W-1:0];

    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == EXP_ONES) && (fa == '0);
    assign b_inf  = (eb == EXP_ONES) && (fb == '0);
    assign a_nan  = (ea == EXP_ONES) && (fa != '0);
    assign b_nan  = (eb == EXP_ONES) && (fb != '0);
    assign swap   = {eb, fb} > {ea, fa};

    // Bits shifted past the sticky position still count toward sticky.
    assign sh_val  = my_q >> diff_q;
    assign sh_mask = ~({M4{1'b1}} << diff_q);
    assign sh_lost = |(my_q & sh_mask);

    assign sum = (sx_q == sy_q) ?
                 ({1'b0, mx_q[M4-1:0]} + {1'b0, my_q}) :
                 ({1'b0, mx_q[M4-1:0]} - {1'b0, my_q});

    assign ex_inc = ex_q + EXP_W'(1);
    assign ex_dec = ex_q - EXP_W'(1);

`ifdef FP_ADDSUB_ROUND_EN
    logic             rnd_up;
    logic [MAN_W+1:0] rnd;
    assign rnd_up = mx_q[2] & (mx_q[1] | mx_q[0] | mx_q[3]);
    assign rnd    = {1'b0, mx_q[M4-1:3]} + (MAN_W+2)'(rnd_up);
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        ex_d    = ex_q;
        diff_d  = diff_q;
        mx_d    = mx_q;
        my_d    = my_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = {b[W-1] ^ op, b[W-2:0]};
                    state_d = ST_UNPACK;
                end
            end
            ST_UNPACK: begin
                state_d = ST_DONE;
                if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
                    res_d = QNAN;
                end else if (a_inf) begin
                    res_d = a_q;
                end else if (b_inf) begin
                    res_d = b_q;
                end else if (a_zero && b_zero) begin
                    res_d = {sa & sb, {(W-1){1'b0}}};
                end else if (a_zero) begin
                    res_d = b_q;
                end else if (b_zero) begin
                    res_d = a_q;
                end else begin
                    sx_d    = swap ? sb : sa;
                    sy_d    = swap ? sa : sb;
                    ex_d    = swap ? eb : ea;
                    diff_d  = swap ? (eb - ea) : (ea - eb);
                    mx_d    = {2'b01, (swap ? fb : fa), 3'b000};
                    my_d    = {1'b1, (swap ? fa : fb), 3'b000};
                    state_d = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (int'(diff_q) >= MAN_W + 3) begin
                    my_d = {{(M4-1){1'b0}}, 1'b1};
                end else begin
                    my_d = sh_val | {{(M4-1){1'b0}}, sh_lost};
                end
                state_d = ST_ADD;
            end
            ST_ADD: begin
                mx_d = sum;
                if (sum == '0) begin
                    res_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                if (mx_q[M4]) begin
                    mx_d = {1'b0, mx_q[M4:2], mx_q[1] | mx_q[0]};
                    ex_d = ex_inc;
                    if (ex_inc == EXP_ONES) begin
                        res_d   = {sx_q, EXP_ONES, {MAN_W{1'b0}}};
                        state_d = ST_DONE;
                    end
                end else if (!mx_q[M4-1]) begin
                    mx_d = {mx_q[M4-1:0], 1'b0};
                    ex_d = ex_dec;
                    if (ex_dec == '0) begin
                        res_d   = {sx_q, {(W-1){1'b0}}};
                        state_d = ST_DONE;
                    end
                end else begin
`ifdef FP_ADDSUB_ROUND_EN
                    state_d = ST_ROUND;
`else
                    res_d   = {sx_q, ex_q, mx_q[M4-2:3]};
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef FP_ADDSUB_ROUND_EN
            ST_ROUND: begin
                if (rnd[MAN_W+1]) begin
                    if (ex_inc == EXP_ONES) begin
                        res_d = {sx_q, EXP_ONES, {MAN_W{1'b0}}};
                    end else begin
                        res_d = {sx_q, ex_inc, {MAN_W{1'b0}}};
                    end
                end else begin
                    res_d = {sx_q, ex_q, rnd[MAN_W-1:0]};
                end
                state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            ex_q    <= '0;
            diff_q  <= '0;
            mx_q    <= '0;
            my_q    <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            ex_q    <= ex_d;
            diff_q  <= diff_d;
            mx_q    <= mx_d;
            my_q    <= my_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = res_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb_fp_addsub_seq: directed vector bench for fp_addsub_seq (single and half precision).
// Expected latencies follow FP_ADDSUB_ROUND_EN when it is defined for the build.
module tb_fp_addsub_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

`ifdef FP_ADDSUB_ROUND_EN
    localparam int RL = 1;
`else
    localparam int RL = 0;
`endif

    logic        start32 = 1'b0, op32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32;
    logic [31:0] res32;

    logic        start16 = 1'b0, op16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16;
    logic [15:0] res16;

    fp_addsub_seq u32 (
        .clk(clk), .rst(rst), .start(start32), .op(op32),
        .a(a32), .b(b32), .busy(busy32), .done(done32), .result(res32)
    );

    fp_addsub_seq #(.EXP_W(5), .MAN_W(10)) u16 (
        .clk(clk), .rst(rst), .start(start16), .op(op16),
        .a(a16), .b(b16), .busy(busy16), .done(done16), .result(res16)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[20];
    int checks = 0;
    int errors = 0;
    logic [31:0] got_r;
    int got_lat;
    bit seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic launch32(input logic [31:0] ia, input logic [31:0] ib, input logic iop);
        @(negedge clk);
        a32 = ia; b32 = ib; op32 = iop; start32 = 1'b1;
        @(posedge clk);
        #1 start32 = 1'b0;
    endtask

    task automatic wait32(input int lat0, output logic [31:0] r, output int lat);
        bit got;
        got = 0; lat = lat0; r = '0;
        while (!got && lat < 300) begin
            @(posedge clk); #1;
            lat++;
            if (done32) begin
                got = 1; r = res32;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL timeout32 got no done want done");
        end else begin
            chk("busy_at_done32", {31'b0, busy32}, 32'd1);
            @(posedge clk); #1;
            chk("idle_after_done32", {30'b0, busy32, done32}, 32'd0);
        end
    endtask

    task automatic run16(input logic [15:0] ia, input logic [15:0] ib,
                         output logic [15:0] r, output int lat);
        bit got;
        @(negedge clk);
        a16 = ia; b16 = ib; op16 = 1'b0; start16 = 1'b1;
        @(posedge clk);
        #1 start16 = 1'b0;
        got = 0; lat = 0; r = '0;
        while (!got && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (done16) begin
                got = 1; r = res16;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL timeout16 got no done want done");
        end
        @(posedge clk); #1;
    endtask

    logic [15:0] r16;

    initial begin
        vecs[0]  = '{32'h3FC00000, 32'h40200000, 1'b0, 32'h40800000, 5 + RL};
        vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3};
        vecs[2]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1};
        vecs[3]  = '{32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 28 + RL};
        vecs[4]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4 + RL};
        vecs[5]  = '{32'h3F800000, 32'h33800001, 1'b0,
                     (RL != 0) ? 32'h3F800001 : 32'h3F800000, 4 + RL};
        vecs[6]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1};
        vecs[7]  = '{32'h00000000, 32'hC0400000, 1'b0, 32'hC0400000, 1};
        vecs[8]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1};
        vecs[9]  = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1};
        vecs[10] = '{32'h40000000, 32'h00000000, 1'b1, 32'h40000000, 1};
        vecs[11] = '{32'h00000000, 32'h40000000, 1'b1, 32'hC0000000, 1};
        vecs[12] = '{32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 1};
        vecs[13] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 1};
        vecs[14] = '{32'h40000000, 32'hC0400000, 1'b0, 32'hBF800000, 5 + RL};
        vecs[15] = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 5 + RL};
        vecs[16] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4};
        vecs[17] = '{32'h4F800000, 32'h3F800000, 1'b0, 32'h4F800000, 4 + RL};
        vecs[18] = '{32'h3F800000, 32'h34000000, 1'b0, 32'h3F800001, 4 + RL};
        vecs[19] = '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4};

        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_busy_done32", {30'b0, busy32, done32}, 32'd0);
        chk("reset_result32", res32, 32'd0);
        chk("reset_busy_done16", {30'b0, busy16, done16}, 32'd0);
        chk("reset_result16", {16'b0, res16}, 32'd0);

        for (int i = 0; i < 20; i++) begin
            launch32(vecs[i].a, vecs[i].b, vecs[i].op);
            wait32(0, got_r, got_lat);
            chk($sformatf("v%0d_result", i), got_r, vecs[i].r);
            chk($sformatf("v%0d_latency", i), 32'(got_lat), 32'(vecs[i].lat));
        end

        // A second start in the middle of a long normalisation must be ignored.
        launch32(32'h3F800000, 32'h3F7FFFFF, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("busy_mid_op", {31'b0, busy32}, 32'd1);
        a32 = 32'h40000000; b32 = 32'h40000000; op32 = 1'b0; start32 = 1'b1;
        @(posedge clk);
        #1 start32 = 1'b0;
        wait32(5, got_r, got_lat);
        chk("ignored_start_result", got_r, 32'h33800000);
        chk("ignored_start_latency", 32'(got_lat), 32'(28 + RL));
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done32) seen = 1;
        end
        chk("no_second_done", {31'b0, seen}, 32'd0);

        // Reset during NORM aborts the operation.
        launch32(32'h3F800000, 32'h3F7FFFFF, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy_done", {30'b0, busy32, done32}, 32'd0);
        chk("abort_result", res32, 32'd0);
        @(negedge clk) rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done32 || busy32) seen = 1;
        end
        chk("abort_no_done", {31'b0, seen}, 32'd0);

        run16(16'h3C00, 16'h3C00, r16, got_lat);
        chk("h_one_plus_one", {16'b0, r16}, 32'h00004000);
        chk("h_one_plus_one_lat", 32'(got_lat), 32'(5 + RL));
        run16(16'h7BFF, 16'h7BFF, r16, got_lat);
        chk("h_overflow", {16'b0, r16}, 32'h00007C00);
        chk("h_overflow_lat", 32'(got_lat), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
